// File: rtl/imem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : imem_arb_pkg
//  Purpose  : Shared types and default widths for the imem port arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package imem_arb_pkg;

  // Identity of the access that owns the memory port in a given cycle.
  typedef enum logic [1:0] {
    REQ_NONE   = 2'd0,
    REQ_FETCH  = 2'd1,
    REQ_DREAD  = 2'd2,
    REQ_DWRITE = 2'd3
  } requester_e;

  localparam int DEF_ADDR_W       = 9;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_STARVE_LIMIT = 4;
  localparam int STARVE_CNT_W     = 4;

endpackage
`default_nettype wire

// File: rtl/imem_arb_starve_ctr.sv
`default_nettype none
// ============================================================================
//  Module   : imem_arb_starve_ctr
//  Purpose  : Saturating counter of consecutive denied fetch cycles; flags
//             when the count has reached LIMIT.
//  Revision : 1.0 - initial release
// ============================================================================
module imem_arb_starve_ctr
  import imem_arb_pkg::*;
#(
  parameter int LIMIT = DEF_STARVE_LIMIT
) (
  input  logic clock,
  input  logic resetn,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_limit_o
);

  localparam logic [STARVE_CNT_W-1:0] c_limit = STARVE_CNT_W'(LIMIT);
  localparam logic [STARVE_CNT_W-1:0] c_one   = STARVE_CNT_W'(1);

  logic [STARVE_CNT_W-1:0] count_q;
  logic [STARVE_CNT_W-1:0] count_d;

  // Next count: clear wins over increment; increment stops at the limit.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != c_limit)) begin
      count_d = count_q + c_one;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign at_limit_o = (count_q == c_limit);

endmodule
`default_nettype wire

// File: rtl/imem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : imem_port_arbiter
//  Purpose  : Shares one single-port instruction BRAM between core fetch,
//             data read and data write. One grant per cycle, default priority
//             write > read > fetch, with fetch promoted to top priority once
//             it has been denied STARVE_LIMIT cycles in a row. Read data
//             returns one cycle after the grant to the requester that won.
//  Options  : IMEM_ARB_STATS_EN - adds 32-bit grant and stall counters.
//  Revision : 1.0 - initial release
// ============================================================================
module imem_port_arbiter
  import imem_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT   // legal range 1..15
) (
  input  logic                clock,
  input  logic                resetn,
  // instruction fetch
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  // data read (byte address)
  input  logic                dr_req_i,
  input  logic [ADDR_W+1:0]   dr_addr_i,
  output logic                dr_gnt_o,
  output logic                dr_rvalid_o,
  output logic [DATA_W-1:0]   dr_rdata_o,
  // data write (byte address)
  input  logic                dw_req_i,
  input  logic [ADDR_W+1:0]   dw_addr_i,
  input  logic [DATA_W-1:0]   dw_wdata_i,
  input  logic [DATA_W/8-1:0] dw_wstrb_i,
  output logic                dw_gnt_o,
`ifdef IMEM_ARB_STATS_EN
  output logic [31:0]         stat_if_cnt_o,
  output logic [31:0]         stat_dr_cnt_o,
  output logic [31:0]         stat_dw_cnt_o,
  output logic [31:0]         stat_stall_cnt_o,
`endif
  // memory port
  output logic                mem_en_o,
  output logic [DATA_W/8-1:0] mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  requester_e w_winner;
  logic       w_at_limit;
  requester_e owner_q;
  requester_e owner_d;

  // Byte-lane bits of the data addresses carry no meaning for a word memory.
  logic w_unused_addr_bits;
  assign w_unused_addr_bits = ^{dr_addr_i[1:0], dw_addr_i[1:0]};

  // Fetch starvation tracking: denied while requesting -> count, else clear.
  imem_arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clock      (clock),
    .resetn     (resetn),
    .inc_i      (if_req_i & ~if_gnt_o),
    .clr_i      (~if_req_i | if_gnt_o),
    .at_limit_o (w_at_limit)
  );

  // Pick the single winner for this cycle; nothing wins while in reset.
  always_comb begin
    w_winner = REQ_NONE;
    if (resetn) begin
      if (w_at_limit && if_req_i) begin
        w_winner = REQ_FETCH;
      end else if (dw_req_i) begin
        w_winner = REQ_DWRITE;
      end else if (dr_req_i) begin
        w_winner = REQ_DREAD;
      end else if (if_req_i) begin
        w_winner = REQ_FETCH;
      end
    end
  end

  assign if_gnt_o = (w_winner == REQ_FETCH);
  assign dr_gnt_o = (w_winner == REQ_DREAD);
  assign dw_gnt_o = (w_winner == REQ_DWRITE);

  // Steer the winner onto the memory port; idle port drives all zeros.
  // A write with no strobes still occupies the port but writes nothing.
  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (w_winner)
      REQ_FETCH: begin
        mem_en_o   = 1'b1;
        mem_addr_o = if_addr_i;
      end
      REQ_DREAD: begin
        mem_en_o   = 1'b1;
        mem_addr_o = dr_addr_i[ADDR_W+1:2];
      end
      REQ_DWRITE: begin
        mem_en_o    = 1'b1;
        mem_we_o    = dw_wstrb_i;
        mem_addr_o  = dw_addr_i[ADDR_W+1:2];
        mem_wdata_o = dw_wdata_i;
      end
      default: begin
        mem_en_o = 1'b0;
      end
    endcase
  end

  // Only reads leave an owner behind; writes and idle cycles leave none.
  always_comb begin
    owner_d = REQ_NONE;
    if (w_winner == REQ_FETCH) begin
      owner_d = REQ_FETCH;
    end else if (w_winner == REQ_DREAD) begin
      owner_d = REQ_DREAD;
    end
  end

  // Remember who owns the read data returning next cycle.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      owner_q <= REQ_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // Reset also masks a read that was in flight when reset arrived.
  assign if_rvalid_o = resetn && (owner_q == REQ_FETCH);
  assign dr_rvalid_o = resetn && (owner_q == REQ_DREAD);
  assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
  assign dr_rdata_o  = dr_rvalid_o ? mem_rdata_i : '0;

`ifdef IMEM_ARB_STATS_EN
  logic [31:0] stat_if_cnt_q;
  logic [31:0] stat_dr_cnt_q;
  logic [31:0] stat_dw_cnt_q;
  logic [31:0] stat_stall_cnt_q;
  logic        w_stall;

  assign w_stall = (if_req_i & ~if_gnt_o) | (dr_req_i & ~dr_gnt_o) |
                   (dw_req_i & ~dw_gnt_o);

  // Free-running wrap-around grant and stall counters.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      stat_if_cnt_q    <= '0;
      stat_dr_cnt_q    <= '0;
      stat_dw_cnt_q    <= '0;
      stat_stall_cnt_q <= '0;
    end else begin
      if (if_gnt_o) stat_if_cnt_q    <= stat_if_cnt_q + 32'd1;
      if (dr_gnt_o) stat_dr_cnt_q    <= stat_dr_cnt_q + 32'd1;
      if (dw_gnt_o) stat_dw_cnt_q    <= stat_dw_cnt_q + 32'd1;
      if (w_stall)  stat_stall_cnt_q <= stat_stall_cnt_q + 32'd1;
    end
  end

  assign stat_if_cnt_o    = stat_if_cnt_q;
  assign stat_dr_cnt_o    = stat_dr_cnt_q;
  assign stat_dw_cnt_o    = stat_dw_cnt_q;
  assign stat_stall_cnt_o = stat_stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_imem_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_imem_port_arbiter
//  Purpose  : Randomized scoreboard bench for imem_port_arbiter with a
//             behavioural memory and arbitration reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_imem_port_arbiter;

  localparam int ADDR_W       = 9;
  localparam int DATA_W       = 32;
  localparam int STARVE_LIMIT = 4;
  localparam int DEPTH        = 1 << ADDR_W;
  localparam int SW           = DATA_W / 8;

  logic                clock  = 1'b0;
  logic                resetn = 1'b0;
  logic                if_req_i = 1'b0;
  logic [ADDR_W-1:0]   if_addr_i = '0;
  logic                dr_req_i = 1'b0;
  logic [ADDR_W+1:0]   dr_addr_i = '0;
  logic                dw_req_i = 1'b0;
  logic [ADDR_W+1:0]   dw_addr_i = '0;
  logic [DATA_W-1:0]   dw_wdata_i = '0;
  logic [SW-1:0]       dw_wstrb_i = '0;
  logic [DATA_W-1:0]   mem_rdata_i;
  logic                if_gnt_o, if_rvalid_o, dr_gnt_o, dr_rvalid_o, dw_gnt_o;
  logic [DATA_W-1:0]   if_rdata_o, dr_rdata_o, mem_wdata_o;
  logic                mem_en_o;
  logic [SW-1:0]       mem_we_o;
  logic [ADDR_W-1:0]   mem_addr_o;
`ifdef IMEM_ARB_STATS_EN
  logic [31:0] stat_if_cnt_o, stat_dr_cnt_o, stat_dw_cnt_o, stat_stall_cnt_o;
`endif

  always #5 clock = ~clock;

  imem_port_arbiter #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_gnt_o    (if_gnt_o),
    .if_rvalid_o (if_rvalid_o),
    .if_rdata_o  (if_rdata_o),
    .dr_req_i    (dr_req_i),
    .dr_addr_i   (dr_addr_i),
    .dr_gnt_o    (dr_gnt_o),
    .dr_rvalid_o (dr_rvalid_o),
    .dr_rdata_o  (dr_rdata_o),
    .dw_req_i    (dw_req_i),
    .dw_addr_i   (dw_addr_i),
    .dw_wdata_i  (dw_wdata_i),
    .dw_wstrb_i  (dw_wstrb_i),
    .dw_gnt_o    (dw_gnt_o),
`ifdef IMEM_ARB_STATS_EN
    .stat_if_cnt_o    (stat_if_cnt_o),
    .stat_dr_cnt_o    (stat_dr_cnt_o),
    .stat_dw_cnt_o    (stat_dw_cnt_o),
    .stat_stall_cnt_o (stat_stall_cnt_o),
`endif
    .mem_en_o    (mem_en_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i)
  );

  // Boot-ROM contents shared by the physical memory and the reference model.
  function automatic logic [DATA_W-1:0] boot_word(input int i);
    if (i == 16) return 32'h0000_0013;
    if (i == 18) return 32'h1122_3344;
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // Physical single-port BRAM attached to the DUT memory port.
  logic [DATA_W-1:0] bram [DEPTH];
  always @(posedge clock) begin
    if (mem_en_o) begin
      for (int b = 0; b < SW; b++)
        if (mem_we_o[b]) bram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      if (mem_we_o == '0) mem_rdata_i <= bram[mem_addr_o];
    end
  end

  // Reference state.
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] fetch_q [$];
  logic [DATA_W-1:0] dread_q [$];
  int starve_n = 0;
  int errors = 0;
  int checks = 0;
  int m_if_cnt = 0, m_dr_cnt = 0, m_dw_cnt = 0, m_stall_cnt = 0;
  logic s_if_gnt = 1'b0, s_dr_gnt = 1'b0, s_dw_gnt = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Evaluate one cycle against the arbitration rules, then update the model.
  task automatic model_cycle();
    int win;                      // 0 none, 1 fetch, 2 data read, 3 data write
    logic [ADDR_W-1:0] wa;
    logic [SW-1:0]     we_exp;
    s_if_gnt = if_gnt_o;
    s_dr_gnt = dr_gnt_o;
    s_dw_gnt = dw_gnt_o;
    if (!resetn) begin
      check("reset_outputs", {if_gnt_o, dr_gnt_o, dw_gnt_o, mem_en_o, mem_we_o,
                              if_rvalid_o, dr_rvalid_o}, 64'd0);
      starve_n = 0;
      m_if_cnt = 0; m_dr_cnt = 0; m_dw_cnt = 0; m_stall_cnt = 0;
      return;
    end
    win = 0;
    if (if_req_i && starve_n >= STARVE_LIMIT) win = 1;
    else if (dw_req_i) win = 3;
    else if (dr_req_i) win = 2;
    else if (if_req_i) win = 1;
    check("grant", {if_gnt_o, dr_gnt_o, dw_gnt_o}, {61'd0, win == 1, win == 2, win == 3});
    case (win)
      1: wa = if_addr_i;
      2: wa = dr_addr_i / 4;
      3: wa = dw_addr_i / 4;
      default: wa = '0;
    endcase
    we_exp = (win == 3) ? dw_wstrb_i : '0;
    check("mem_port", {mem_en_o, mem_we_o, mem_addr_o}, {50'd0, win != 0, we_exp, wa});
    if (win == 3) check("mem_wdata", mem_wdata_o, dw_wdata_i);
    if (win == 1) fetch_q.push_back(ref_mem[wa]);
    if (win == 2) dread_q.push_back(ref_mem[wa]);
    if (win == 3)
      for (int b = 0; b < SW; b++)
        if (dw_wstrb_i[b]) ref_mem[wa][8*b +: 8] = dw_wdata_i[8*b +: 8];
    if (if_req_i && win != 1) starve_n = (starve_n < STARVE_LIMIT) ? starve_n + 1 : STARVE_LIMIT;
    else starve_n = 0;
    if (win == 1) m_if_cnt++;
    if (win == 2) m_dr_cnt++;
    if (win == 3) m_dw_cnt++;
    if ((if_req_i && win != 1) || (dr_req_i && win != 2) || (dw_req_i && win != 3)) m_stall_cnt++;
  endtask

  // Check at mid-cycle, then advance to just after the next rising edge.
  task automatic tick();
    @(negedge clock);
    model_cycle();
    @(posedge clock);
    #1;
  endtask

  // Requesters drop their request once it has been accepted.
  task automatic release_granted();
    if (s_if_gnt) if_req_i = 1'b0;
    if (s_dr_gnt) dr_req_i = 1'b0;
    if (s_dw_gnt) dw_req_i = 1'b0;
  endtask

  task automatic do_reset(input int n);
    resetn = 1'b0;
    fetch_q.delete();
    dread_q.delete();
    repeat (n) tick();
    resetn = 1'b1;
  endtask

  // Monitor: read data is due exactly one cycle after its grant.
  initial begin
    logic [DATA_W-1:0] e;
    forever begin
      @(posedge clock);
      #2;
      if (if_rvalid_o) begin
        if (fetch_q.size() == 0) check("if_rvalid_unexpected", 64'(if_rvalid_o), 64'd0);
        else begin e = fetch_q.pop_front(); check("if_rdata", if_rdata_o, e); end
      end else begin
        if (fetch_q.size() != 0) begin
          void'(fetch_q.pop_front());
          check("if_rvalid_missing", 64'(if_rvalid_o), 64'd1);
        end
        check("if_rdata_idle", if_rdata_o, 64'd0);
      end
      if (dr_rvalid_o) begin
        if (dread_q.size() == 0) check("dr_rvalid_unexpected", 64'(dr_rvalid_o), 64'd0);
        else begin e = dread_q.pop_front(); check("dr_rdata", dr_rdata_o, e); end
      end else begin
        if (dread_q.size() != 0) begin
          void'(dread_q.pop_front());
          check("dr_rvalid_missing", 64'(dr_rvalid_o), 64'd1);
        end
        check("dr_rdata_idle", dr_rdata_o, 64'd0);
      end
    end
  end

  // Stimulus.
  initial begin
    int first_if;
    for (int i = 0; i < DEPTH; i++) begin
      bram[i]    <= boot_word(i);
      ref_mem[i]  = boot_word(i);
    end
    @(posedge clock);
    #1;
    do_reset(3);

    // Lone fetch of the boot word.
    if_req_i = 1'b1; if_addr_i = 9'h010;
    tick(); release_granted();
    #1 check("t1_fetch_data", {if_rvalid_o, if_rdata_o}, {31'd0, 1'b1, 32'h0000_0013});

    // Write, read-after-write and fetch all at once.
    dw_req_i = 1'b1; dw_addr_i = 11'h040; dw_wdata_i = 32'hDEAD_BEEF; dw_wstrb_i = 4'hF;
    dr_req_i = 1'b1; dr_addr_i = 11'h040;
    if_req_i = 1'b1; if_addr_i = 9'h005;
    tick(); release_granted();
    tick(); release_granted();
    #1 check("t2_raw_data", {dr_rvalid_o, dr_rdata_o}, {31'd0, 1'b1, 32'hDEAD_BEEF});
    repeat (2) begin tick(); release_granted(); end

    // Continuous data reads starve the fetch until the limit.
    first_if = 0;
    dr_req_i = 1'b1; dr_addr_i = 11'h100;
    if_req_i = 1'b1; if_addr_i = 9'h020;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (s_if_gnt && first_if == 0) begin first_if = k; if_req_i = 1'b0; end
    end
    check("t3_starve_grant_cycle", 64'(first_if), 64'd5);
    dr_req_i = 1'b0;
    tick();

    // Single-byte-lane write merge.
    dw_req_i = 1'b1; dw_addr_i = 11'h048; dw_wdata_i = 32'h0000_AB00; dw_wstrb_i = 4'h2;
    tick(); release_granted();
    dr_req_i = 1'b1; dr_addr_i = 11'h048;
    tick(); release_granted();
    #1 check("t4_byte_merge", {dr_rvalid_o, dr_rdata_o}, {31'd0, 1'b1, 32'h1122_AB44});
    tick();

    // Reset right after a data-read grant drops the read.
    dr_req_i = 1'b1; dr_addr_i = 11'h048;
    tick(); release_granted();
    if_req_i = 1'b1; if_addr_i = 9'h010;
    resetn = 1'b0;
    fetch_q.delete(); dread_q.delete();
    #1 check("t5_read_dropped", 64'(dr_rvalid_o), 64'd0);
    repeat (2) tick();
    resetn = 1'b1;
    tick(); release_granted();
    #1 check("t5_post_reset_fetch", {if_rvalid_o, if_rdata_o}, {31'd0, 1'b1, 32'hDEAD_BEEF});

    // Randomized traffic under the hold-until-grant protocol.
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset(2);
      if (!if_req_i) begin
        if ($urandom_range(0, 99) < 60) begin
          if_req_i  = 1'b1;
          if_addr_i = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 31));
        end
      end else if ($urandom_range(0, 99) < 2) if_req_i = 1'b0;
      if (!dr_req_i) begin
        if ($urandom_range(0, 99) < 45) begin
          dr_req_i  = 1'b1;
          dr_addr_i = (ADDR_W+2)'($urandom_range(0, 127));
        end
      end else if ($urandom_range(0, 99) < 2) dr_req_i = 1'b0;
      if (!dw_req_i) begin
        if ($urandom_range(0, 99) < 35) begin
          dw_req_i   = 1'b1;
          dw_addr_i  = (ADDR_W+2)'($urandom_range(0, 127));
          dw_wdata_i = $urandom;
          dw_wstrb_i = SW'($urandom_range(0, 15));
        end
      end else if ($urandom_range(0, 99) < 2) dw_req_i = 1'b0;
      tick();
      release_granted();
    end
    if_req_i = 1'b0; dr_req_i = 1'b0; dw_req_i = 1'b0;
    repeat (2) tick();

`ifdef IMEM_ARB_STATS_EN
    check("stat_if_cnt",    stat_if_cnt_o,    64'(m_if_cnt));
    check("stat_dr_cnt",    stat_dr_cnt_o,    64'(m_dr_cnt));
    check("stat_dw_cnt",    stat_dw_cnt_o,    64'(m_dw_cnt));
    check("stat_stall_cnt", stat_stall_cnt_o, 64'(m_stall_cnt));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
